// File: rtl/ssd_mux_scheduler.sv
// Two-digit seven-segment display multiplexer with a double-buffered value that is only
// committed at frame boundaries, so both digits of one frame always come from the same value.
module ssd_mux_scheduler #(
  parameter int unsigned DWELL_CYCLES = 1000,
  parameter int unsigned BLANK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       wr_valid,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  input  logic       lz_blank,
  output logic [7:0] uo_out,
  output logic       frame_done
);

  localparam int unsigned CntBig  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int unsigned CntSpan = (CntBig < 2) ? 2 : CntBig;
  localparam int unsigned CntW    = $clog2(CntSpan);
  localparam bit          HasBlank = (BLANK_CYCLES != 0);

  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
  localparam logic [CntW-1:0] BlankLast = CntW'((BLANK_CYCLES == 0) ? 0 : BLANK_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StShowOnes,
    StBlankA,
    StShowTens,
    StBlankB
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [7:0]        active_q, active_d;
  logic [7:0]        shadow_q, shadow_d;
  logic              pending_q, pending_d;
  logic [7:0]        uo_out_q, uo_out_d;
  logic              frame_done_q, frame_done_d;
  logic              frame_end, commit, accept;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (ena) begin
          state_d = StShowOnes;
          cnt_d   = '0;
        end
      end
      StShowOnes: begin
        if (cnt_q == DwellLast) begin
          cnt_d   = '0;
          state_d = HasBlank ? StBlankA : StShowTens;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBlankA: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StShowTens;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StShowTens: begin
        if (cnt_q == DwellLast) begin
          cnt_d   = '0;
          state_d = HasBlank ? StBlankB : StShowOnes;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StBlankB: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StShowOnes;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    if (!ena) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  // Commit only at the frame boundary (or immediately while idle); accept only when the shadow
  // is free, so the two never happen on the same edge.
  always_comb begin
    frame_end = HasBlank ? (state_q == StBlankB && cnt_q == BlankLast)
                         : (state_q == StShowTens && cnt_q == DwellLast);
    commit    = pending_q && (frame_end || state_q == StIdle);
    accept    = wr_valid && !pending_q;
    active_d  = commit ? shadow_q : active_q;
    shadow_d  = accept ? wr_data : shadow_q;
    pending_d = accept || (pending_q && !commit);
  end

  // Outputs are registered from the next state so they switch on the same edge as the state.
  always_comb begin
    uo_out_d = 8'h00;
    unique case (state_d)
      StShowOnes: uo_out_d = {1'b0, hex_seg(active_d[3:0])};
      StShowTens: begin
        if (lz_blank && active_d[7:4] == 4'h0) uo_out_d = 8'h80;
        else                                   uo_out_d = {1'b1, hex_seg(active_d[7:4])};
      end
      StBlankB:   uo_out_d = 8'h80;
      default:    uo_out_d = 8'h00;
    endcase
    frame_done_d = HasBlank ? (state_d == StBlankB && cnt_d == BlankLast)
                            : (state_d == StShowTens && cnt_d == DwellLast);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      active_q     <= 8'h00;
      shadow_q     <= 8'h00;
      pending_q    <= 1'b0;
      uo_out_q     <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      uo_out_q     <= uo_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign wr_ready   = !pending_q;
  assign uo_out     = uo_out_q;
  assign frame_done = frame_done_q;

endmodule
